// File: rtl/hold_div_responder_pkg.sv
// Shared types and sizing helpers for the hold-handshake restoring divider.
package hold_div_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/hold_div_responder_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when there is no borrow.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // Extra top bit of trial is the borrow out of the WIDTH+1-bit subtraction.
  assign shifted = {rem_i, bit_i};
  assign trial   = {1'b0, shifted} - {2'b00, divisor_i};
  assign q_o     = ~trial[WIDTH+1];
  assign rem_o   = q_o ? WIDTH'(trial) : WIDTH'(shifted);

endmodule

// File: rtl/hold_div_responder.sv
// Responder side of the valid/done hold handshake wrapped around an iterative
// unsigned restoring divider producing one quotient bit per cycle.
module hold_div_responder
  import hold_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             data_ok,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_w_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] quo_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .q_o       (step_bit)
  );

  assign quo_next = WIDTH'({quo_w_q, step_bit});

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quo_w_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (valid) begin
            busy_q <= 1'b1;
            if (divisor == '0) begin
              err_q       <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              err_q   <= 1'b0;
              dvd_q   <= dividend;
              dsr_q   <= divisor;
              rem_q   <= '0;
              quo_w_q <= '0;
              cnt_q   <= CNT_INIT;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          // Requester dropped valid early: abandon without touching results.
          if (!valid) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            rem_q   <= step_rem;
            quo_w_q <= quo_next;
            dvd_q   <= dvd_q << 1;
            cnt_q   <= cnt_q - CNT_LAST;
            if (cnt_q == CNT_LAST) begin
              quotient_q  <= quo_next;
              remainder_q <= step_rem;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    data_ok = 1'b1;
    if (state_q == IDLE) begin
      data_ok = !(valid && (divisor == '0));
    end else begin
      data_ok = !err_q;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
